// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with grant-acceptance timeout
//
// Purpose: grants a shared bus to one of NUM_MASTERS requesters in round-robin
// order. A granted master must start using the bus (b_bus_utilizing) within
// 2^TIMEOUT_LEN cycles, or it must keep requesting. If it withdraws its request
// or the wait times out, the grant is revoked. Every grant is followed by one
// RELEASE cycle and one IDLE cycle before the next grant.
//
// Ports:
//   clk             - single clock, rising edge
//   rstn            - synchronous active-low reset
//   b_request       - per-master request, bit i from master i
//   b_bus_utilizing - shared bus-in-use line driven by the granted master
//   b_grant         - registered one-hot grant
//   grant_id        - index of the current or most recently granted master
//   arb_busy        - high whenever the arbiter is not idle
//   arb_timeout     - one-cycle pulse in the RELEASE cycle after a timeout
module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT_LEN = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [1:0]             grant_id,
  output logic                   arb_busy,
  output logic                   arb_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] LAST_RESET = 2'(NUM_MASTERS - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [TIMEOUT_LEN-1:0]   wait_cnt;
  logic [TIMEOUT_LEN-1:0]   wait_cnt_nxt;
  logic [1:0]               last_grant;
  logic [1:0]               last_grant_nxt;
  logic [NUM_MASTERS-1:0]   grant_nxt;
  logic [1:0]               grant_id_nxt;
  logic                     busy_nxt;
  logic                     timeout_nxt;

  // Requests padded to four bits so any 2-bit master index is a legal select.
  logic [3:0]               req_pad;
  logic [2:0]               rr_idx;
  logic [1:0]               rr_winner;
  logic                     rr_found;
  logic [NUM_MASTERS-1:0]   rr_onehot;

  assign req_pad = 4'(b_request);

  // Round-robin scan: candidates last_grant+1, last_grant+2, ... modulo
  // NUM_MASTERS, so the previous winner is considered last.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_grant;
    rr_idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_idx = {1'b0, last_grant} + 3'(k);
      if (rr_idx >= 3'(NUM_MASTERS)) begin
        rr_idx = rr_idx - 3'(NUM_MASTERS);
      end
      if (!rr_found && req_pad[rr_idx[1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx[1:0];
      end
    end
  end

  always_comb begin
    rr_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_onehot[i] = (rr_winner == 2'(i));
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = b_grant;
    grant_id_nxt   = grant_id;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    timeout_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        grant_nxt = '0;
        // Foreign bus activity blocks any new grant.
        if (!b_bus_utilizing && rr_found) begin
          state_nxt    = S_GRANT;
          grant_nxt    = rr_onehot;
          grant_id_nxt = rr_winner;
          wait_cnt_nxt = '0;
        end
      end

      S_GRANT: begin
        if (b_bus_utilizing) begin
          state_nxt = S_BUSY;
        end else if (!req_pad[grant_id]) begin
          state_nxt = S_RELEASE;
          grant_nxt = '0;
        end else if (wait_cnt == '1) begin
          state_nxt   = S_RELEASE;
          grant_nxt   = '0;
          timeout_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      S_BUSY: begin
        if (!b_bus_utilizing) begin
          state_nxt = S_RELEASE;
          grant_nxt = '0;
        end
      end

      S_RELEASE: begin
        state_nxt      = S_IDLE;
        grant_nxt      = '0;
        last_grant_nxt = grant_id;
        wait_cnt_nxt   = '0;
      end

      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      b_grant     <= '0;
      grant_id    <= LAST_RESET;
      arb_busy    <= 1'b0;
      arb_timeout <= 1'b0;
      wait_cnt    <= '0;
      last_grant  <= LAST_RESET;
    end else begin
      state       <= state_nxt;
      b_grant     <= grant_nxt;
      grant_id    <= grant_id_nxt;
      arb_busy    <= busy_nxt;
      arb_timeout <= timeout_nxt;
      wait_cnt    <= wait_cnt_nxt;
      last_grant  <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (NUM_MASTERS=2, TIMEOUT_LEN=4)
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int TL = 4;
  localparam int TMAX = (1 << TL) - 1;

  logic         clk;
  logic         rstn;
  logic [N-1:0] b_request;
  logic         b_bus_utilizing;
  logic [N-1:0] b_grant;
  logic [1:0]   grant_id;
  logic         arb_busy;
  logic         arb_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_LEN(TL)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .b_request       (b_request),
    .b_bus_utilizing (b_bus_utilizing),
    .b_grant         (b_grant),
    .grant_id        (grant_id),
    .arb_busy        (arb_busy),
    .arb_timeout     (arb_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: who owns the bus, whether it is on the bus, how long it
  // has waited, and whether we are in the post-grant release gap.
  int       m_owner = -1;
  int       m_onbus = 0;
  int       m_age   = 0;
  int       m_rel   = 0;
  int       m_last  = N - 1;
  int       m_id    = N - 1;
  int       m_to    = 0;
  logic [N-1:0] s_req;
  logic     s_util;
  logic     s_rstn;

  task automatic model_step();
    m_to = 0;
    if (!s_rstn) begin
      m_owner = -1; m_onbus = 0; m_age = 0; m_rel = 0;
      m_last = N - 1; m_id = N - 1;
    end else if (m_rel != 0) begin
      m_rel  = 0;
      m_last = m_id;
    end else if (m_owner < 0) begin
      if (!s_util && s_req != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && s_req[(m_last + k) % N]) m_owner = (m_last + k) % N;
        end
        m_id = m_owner; m_age = 0; m_onbus = 0;
      end
    end else if (m_onbus != 0) begin
      if (!s_util) begin
        m_rel = 1; m_owner = -1; m_onbus = 0;
      end
    end else begin
      if (s_util) m_onbus = 1;
      else if (!s_req[m_owner]) begin
        m_rel = 1; m_owner = -1;
      end else if (m_age == TMAX) begin
        m_rel = 1; m_owner = -1; m_to = 1;
      end else m_age++;
    end
  endtask

  // Per-cycle compare against the model, sampled at the falling edge.
  initial begin
    logic [N-1:0] exp_g;
    forever begin
      @(posedge clk);
      s_req = b_request; s_util = b_bus_utilizing; s_rstn = rstn;
      @(negedge clk);
      model_step();
      exp_g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("model_b_grant", 32'(b_grant), 32'(exp_g));
      chk("model_grant_id", 32'(grant_id), 32'(m_id));
      chk("model_arb_busy", 32'(arb_busy), 32'((m_owner >= 0 || m_rel != 0) ? 1 : 0));
      chk("model_arb_timeout", 32'(arb_timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int hist_g [1:60];
  int hist_to[1:60];
  int seg_val[$];
  int seg_len[$];
  int to_cnt;

  initial begin
    rstn = 1'b0; b_request = '0; b_bus_utilizing = 1'b0;
    tick(); tick(); tick();
    chk("reset_b_grant", 32'(b_grant), 32'h0);
    chk("reset_grant_id", 32'(grant_id), 32'd1);
    chk("reset_arb_busy", 32'(arb_busy), 32'd0);
    chk("reset_arb_timeout", 32'(arb_timeout), 32'd0);

    // First grant after reset goes to master 0 with one-cycle latency.
    rstn = 1'b1; tick();
    b_request = 2'b01; tick();
    chk("first_grant", 32'(b_grant), 32'h1);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    chk("first_busy", 32'(arb_busy), 32'd1);

    // Bus in use for 10 cycles: grant held, then one RELEASE cycle, then IDLE.
    b_bus_utilizing = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_hold_grant", 32'(b_grant), 32'h1);
    end
    b_bus_utilizing = 1'b0; b_request = 2'b00; tick();
    chk("release_grant", 32'(b_grant), 32'h0);
    chk("release_busy", 32'(arb_busy), 32'd1);
    tick();
    chk("idle_busy", 32'(arb_busy), 32'd0);
    chk("idle_grant_id_held", 32'(grant_id), 32'd0);

    // Both requesting, nobody uses the bus: timeouts and alternation.
    rstn = 1'b0; tick();
    rstn = 1'b1; tick();
    b_request = 2'b11;
    for (int t = 1; t <= 60; t++) begin
      tick();
      hist_g[t]  = int'(b_grant);
      hist_to[t] = int'(arb_timeout);
    end
    for (int t = 1; t <= 60; t++) begin
      if (t == 1 || hist_g[t] != hist_g[t-1]) begin
        seg_val.push_back(hist_g[t]);
        seg_len.push_back(1);
      end else begin
        seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
      end
    end
    chk("rr_segments_enough", 32'(seg_val.size() >= 5), 32'd1);
    if (seg_val.size() >= 5) begin
      chk("rr_seg0_val", 32'(seg_val[0]), 32'h1);
      chk("rr_seg0_len", 32'(seg_len[0]), 32'd16);
      chk("rr_gap0_val", 32'(seg_val[1]), 32'h0);
      chk("rr_gap0_len", 32'(seg_len[1]), 32'd2);
      chk("rr_seg1_val", 32'(seg_val[2]), 32'h2);
      chk("rr_seg1_len", 32'(seg_len[2]), 32'd16);
      chk("rr_gap1_len", 32'(seg_len[3]), 32'd2);
      chk("rr_seg2_val", 32'(seg_val[4]), 32'h1);
    end
    to_cnt = 0;
    for (int t = 1; t <= 60; t++) to_cnt += hist_to[t];
    chk("timeout_pulse_count", 32'(to_cnt), 32'd3);
    chk("timeout_at_release", 32'(hist_to[17]), 32'd1);
    chk("no_timeout_in_grant", 32'(hist_to[16]), 32'd0);

    // Foreign bus activity in IDLE blocks the grant.
    b_request = 2'b00;
    rstn = 1'b0; tick();
    rstn = 1'b1; tick();
    b_bus_utilizing = 1'b1; b_request = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("foreign_no_grant", 32'(b_grant), 32'h0);
    end
    b_bus_utilizing = 1'b0; tick();
    chk("foreign_then_grant", 32'(b_grant), 32'h2);
    chk("foreign_grant_id", 32'(grant_id), 32'd1);

    // Reset during BUSY drops the grant at that edge; master 0 wins next.
    b_bus_utilizing = 1'b1; tick(); tick();
    chk("busy_before_reset", 32'(b_grant), 32'h2);
    rstn = 1'b0; tick();
    chk("reset_in_busy_grant", 32'(b_grant), 32'h0);
    chk("reset_in_busy_busy", 32'(arb_busy), 32'd0);
    rstn = 1'b1; b_bus_utilizing = 1'b0; b_request = 2'b11; tick();
    chk("after_reset_master0", 32'(b_grant), 32'h1);

    // Master 0 withdraws: RELEASE without timeout, then master 1 served.
    b_request = 2'b10; tick();
    chk("withdraw_release", 32'(b_grant), 32'h0);
    chk("withdraw_no_timeout", 32'(arb_timeout), 32'd0);
    tick();
    chk("withdraw_idle", 32'(b_grant), 32'h0);
    tick();
    chk("withdraw_next_master1", 32'(b_grant), 32'h2);

    b_request = 2'b00;
    tick(); tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
